rx_param_deserializer: RTL and testbench
========================================

RX_PARAM_DESERIALIZER -- requirements
Module: rx_param_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = first received data bit lands in bit 0; 0 = first bit lands in bit DATA_WIDTH-1.
REQ-003 SHALL have parameter PARITY_EN, default 0: 1 = one parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have port clk_based_on_prescale, input, 1 bit: the single clock, rising-edge.
REQ-006 SHALL have port asy_reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port frame_start, input, 1 bit: one-cycle pulse from the RX FSM marking an accepted start bit.
REQ-008 SHALL have port sampled_data, input, 1 bit: the majority-sampled line value.
REQ-009 SHALL have port sampled_data_valid, input, 1 bit: qualifies sampled_data for one cycle.
REQ-010 SHALL have port parallel_data, output, DATA_WIDTH bits: the received word.
REQ-011 SHALL have port data_valid, output, 1 bit: parallel_data and parity_err are valid.
REQ-012 SHALL have port data_ready, input, 1 bit: consumer accepts the word.
REQ-013 SHALL have port parity_err, output, 1 bit: sideband to the word; its parity check failed.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.
REQ-015 SHALL have port overrun_err, output, 1 bit: one-cycle pulse when a good frame is dropped because the holding register is full.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-018 Transitions SHALL be: IDLE->DATA on frame_start; DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) on the DATA_WIDTH-th qualified bit; PARITY->STOP on one qualified bit; STOP->IDLE on one qualified bit.
REQ-019 A qualified bit SHALL be sampled_data_valid=1 while in DATA, PARITY or STOP; sampled_data_valid SHALL be ignored in IDLE.
REQ-020 In DATA, the bit counter SHALL have width $clog2(DATA_WIDTH+1) and SHALL clear on entry to DATA.
REQ-021 Shifting SHALL follow LSB_FIRST: shift right with new bit at MSB when LSB_FIRST=1; shift left with new bit at LSB when LSB_FIRST=0.
REQ-022 A running parity (XOR of data bits) SHALL be kept; parity fails when XOR(data, parity bit) != PARITY_ODD.
REQ-023 In STOP, a qualified bit of 1 SHALL commit the frame; a qualified bit of 0 SHALL discard it and pulse frame_err in the next cycle.
REQ-024 On commit, if data_valid=0 or (data_valid and data_ready), parallel_data/parity_err SHALL load and data_valid SHALL be 1 in the next cycle (latency: 1 cycle after the stop-bit sample).
REQ-025 On commit with data_valid=1 and data_ready=0, the frame SHALL be dropped, the held word kept unchanged, and overrun_err pulsed for one cycle.
REQ-026 data_valid SHALL clear the cycle after data_valid and data_ready are both 1, unless a commit reloads it in the same cycle.
REQ-027 parallel_data SHALL be stable while data_valid=1 and data_ready=0.
REQ-028 frame_start in any non-IDLE state SHALL abort the current frame silently (no error flags) and restart DATA with a cleared counter.
REQ-029 Simultaneous frame_start and sampled_data_valid SHALL give priority to frame_start; that bit is not consumed.

Reset
REQ-030 asy_reset=1 SHALL immediately force: state IDLE, counter 0, shift register 0, parallel_data 0, data_valid 0, parity_err 0, frame_err 0, overrun_err 0, busy 0.
REQ-031 Reset asserted mid-frame or with a word held SHALL discard both; no outputs pulse after release until a new frame commits.

Structure
REQ-032 Shared package rx_pkg SHALL hold the FSM state typedef and the constants DATA_WIDTH_MIN=5 and DATA_WIDTH_MAX=9.
REQ-033 An out-of-range DATA_WIDTH SHALL cause an elaboration-time error.
REQ-034 A sub-module rx_shift_reg SHALL contain the shift register, bit-order mux and running parity; the FSM, holding register and error logic SHALL be in the top level.

Verification
REQ-035 Defaults, data_ready=1, bits 1,0,1,0,0,1,0,1 then stop 1 -> parallel_data=0xA5, data_valid=1 for exactly 1 cycle.
REQ-036 LSB_FIRST=0, DATA_WIDTH=7, bits 1,0,0,0,0,0,1, stop 1 -> parallel_data=7'h41.
REQ-037 PARITY_EN=1, PARITY_ODD=0, data 0x03, parity bit 1, stop 1 -> word delivered with parity_err=1; with parity bit 0 -> parity_err=0.
REQ-038 Stop bit 0 -> frame_err pulses for 1 cycle, data_valid stays 0.
REQ-039 data_ready=0, frames 0x11 then 0x22 -> 0x11 held, overrun_err pulses once; raising data_ready -> 0x11 consumed, data_valid falls.
REQ-040 asy_reset pulsed after 4 data bits, then a full frame 0x5A -> only 0x5A delivered, no error pulses.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the RX deserializer: FSM state encoding, legal
// width bounds and the parity check helper.
package rx_pkg;

    localparam int DATA_WIDTH_MIN = 32'd5;
    localparam int DATA_WIDTH_MAX = 32'd9;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 2'd0;
    localparam rx_state_t ST_DATA   = 2'd1;
    localparam rx_state_t ST_PARITY = 2'd2;
    localparam rx_state_t ST_STOP   = 2'd3;

    // True when the received parity bit does not match the configured sense.
    function automatic logic parity_fail(input logic data_xor,
                                         input logic parity_bit,
                                         input logic odd);
        return ((data_xor ^ parity_bit) != odd);
    endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// Data shift register with selectable bit order and a running XOR of all
// shifted-in bits.
module rx_shift_reg
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic                  bit_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  parity_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  parity_q;
    logic                  parity_d;

    // Next-state: clear wins, otherwise shift in the new bit in configured order.
    always_comb begin
        data_d   = data_q;
        parity_d = parity_q;
        if (clear_i) begin
            data_d   = {DATA_WIDTH{1'b0}};
            parity_d = 1'b0;
        end else if (shift_i) begin
            if (LSB_FIRST != 0) begin
                data_d = {bit_i, data_q[DATA_WIDTH-1:1]};
            end else begin
                data_d = {data_q[DATA_WIDTH-2:0], bit_i};
            end
            parity_d = parity_q ^ bit_i;
        end else begin
            data_d   = data_q;
            parity_d = parity_q;
        end
    end

    // Shift register and running parity state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q   <= {DATA_WIDTH{1'b0}};
            parity_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            parity_q <= parity_d;
        end
    end

    assign data_o   = data_q;
    assign parity_o = parity_q;

endmodule

// File: rtl/rx_param_deserializer.sv
// UART-style receive deserializer: frame FSM, one-word holding register with
// valid/ready hand-off, and frame/parity/overrun error reporting.
module rx_param_deserializer
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic                  frame_start,
    input  logic                  sampled_data,
    input  logic                  sampled_data_valid,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);

    if ((DATA_WIDTH < DATA_WIDTH_MIN) || (DATA_WIDTH > DATA_WIDTH_MAX)) begin : g_width_check
        $error("rx_param_deserializer: DATA_WIDTH %0d outside legal range", DATA_WIDTH);
    end

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic             ODD_SEL  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    rx_state_t             state_q;
    rx_state_t             state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  perr_pend_q;
    logic                  perr_pend_d;
    logic [DATA_WIDTH-1:0] pdata_q;
    logic [DATA_WIDTH-1:0] pdata_d;
    logic                  dvalid_q;
    logic                  dvalid_d;
    logic                  perr_q;
    logic                  perr_d;
    logic                  ferr_q;
    logic                  ferr_d;
    logic                  ovr_q;
    logic                  ovr_d;
    logic                  busy_q;
    logic                  busy_d;

    logic                  qual_s;
    logic                  shift_s;
    logic                  commit_s;
    logic                  stop_bad_s;
    logic                  load_s;
    logic                  drop_s;
    logic [DATA_WIDTH-1:0] shreg_data_s;
    logic                  shreg_par_s;

    // frame_start outranks a same-cycle sample, so that bit is never consumed.
    assign qual_s     = sampled_data_valid && (state_q != ST_IDLE) && !frame_start;
    assign shift_s    = qual_s && (state_q == ST_DATA);
    assign commit_s   = qual_s && (state_q == ST_STOP) && sampled_data;
    assign stop_bad_s = qual_s && (state_q == ST_STOP) && !sampled_data;
    assign load_s     = commit_s && (!dvalid_q || data_ready);
    assign drop_s     = commit_s && dvalid_q && !data_ready;

    rx_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shift_reg (
        .clk_i    (clk_based_on_prescale),
        .rst_i    (asy_reset),
        .clear_i  (frame_start),
        .shift_i  (shift_s),
        .bit_i    (sampled_data),
        .data_o   (shreg_data_s),
        .parity_o (shreg_par_s)
    );

    // Frame FSM, bit counter and latched parity verdict.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        perr_pend_d = perr_pend_q;
        if (frame_start) begin
            state_d     = ST_DATA;
            cnt_d       = {CNT_W{1'b0}};
            perr_pend_d = 1'b0;
        end else if (qual_s) begin
            case (state_q)
                ST_DATA: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    perr_pend_d = parity_fail(shreg_par_s, sampled_data, ODD_SEL);
                    state_d     = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            perr_pend_d = perr_pend_q;
        end
    end

    // Holding register: load on commit when free or being drained, else hold.
    always_comb begin
        pdata_d  = pdata_q;
        perr_d   = perr_q;
        dvalid_d = dvalid_q;
        if (load_s) begin
            pdata_d  = shreg_data_s;
            perr_d   = (PARITY_EN != 0) ? perr_pend_q : 1'b0;
            dvalid_d = 1'b1;
        end else if (dvalid_q && data_ready) begin
            dvalid_d = 1'b0;
        end else begin
            dvalid_d = dvalid_q;
        end
        ferr_d = stop_bad_s;
        ovr_d  = drop_s;
        busy_d = (state_d != ST_IDLE);
    end

    // All state and output registers.
    always_ff @(posedge clk_based_on_prescale or posedge asy_reset) begin
        if (asy_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            perr_pend_q <= 1'b0;
            pdata_q     <= {DATA_WIDTH{1'b0}};
            dvalid_q    <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            perr_pend_q <= perr_pend_d;
            pdata_q     <= pdata_d;
            dvalid_q    <= dvalid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
        end
    end

    assign parallel_data = pdata_q;
    assign data_valid    = dvalid_q;
    assign parity_err    = perr_q;
    assign frame_err     = ferr_q;
    assign overrun_err   = ovr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_rx_param_deserializer.sv
// Scoreboard bench for rx_param_deserializer: three configurations driven by
// directed frames, with a negedge monitor checking every presented word.
module tb_rx_param_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       fs  [3];
    logic       sd  [3];
    logic       sv  [3];
    logic       rdy [3];
    logic       dv  [3];
    logic       pe  [3];
    logic       fe  [3];
    logic       ov  [3];
    logic       bz  [3];
    logic [7:0] pd0;
    logic [6:0] pd1;
    logic [7:0] pd2;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
    } exp_t;

    exp_t exq [3][$];
    int   checks = 0;
    int   errors = 0;
    int   fe_cnt  [3];
    int   ov_cnt  [3];
    int   dvh_cnt [3];

    rx_param_deserializer u_dut0 (
        .clk_based_on_prescale (clk), .asy_reset (rst),
        .frame_start (fs[0]), .sampled_data (sd[0]), .sampled_data_valid (sv[0]),
        .parallel_data (pd0), .data_valid (dv[0]), .data_ready (rdy[0]),
        .parity_err (pe[0]), .frame_err (fe[0]), .overrun_err (ov[0]), .busy (bz[0])
    );

    rx_param_deserializer #(.DATA_WIDTH(7), .LSB_FIRST(0)) u_dut1 (
        .clk_based_on_prescale (clk), .asy_reset (rst),
        .frame_start (fs[1]), .sampled_data (sd[1]), .sampled_data_valid (sv[1]),
        .parallel_data (pd1), .data_valid (dv[1]), .data_ready (rdy[1]),
        .parity_err (pe[1]), .frame_err (fe[1]), .overrun_err (ov[1]), .busy (bz[1])
    );

    rx_param_deserializer #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut2 (
        .clk_based_on_prescale (clk), .asy_reset (rst),
        .frame_start (fs[2]), .sampled_data (sd[2]), .sampled_data_valid (sv[2]),
        .parallel_data (pd2), .data_valid (dv[2]), .data_ready (rdy[2]),
        .parity_err (pe[2]), .frame_err (fe[2]), .overrun_err (ov[2]), .busy (bz[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // A presented word must match the queue head every cycle it is shown.
    task automatic mon(input int i, input logic [8:0] pdv);
        if (fe[i]) fe_cnt[i]++;
        if (ov[i]) ov_cnt[i]++;
        if (dv[i]) begin
            dvh_cnt[i]++;
            if (exq[i].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word dut%0d: got %0h required no word", i, pdv);
            end else begin
                chk($sformatf("word_data dut%0d", i), {23'd0, pdv}, {23'd0, exq[i][0].data});
                chk($sformatf("word_perr dut%0d", i), {31'd0, pe[i]}, {31'd0, exq[i][0].perr});
                if (rdy[i]) void'(exq[i].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, {1'b0, pd0});
        mon(1, {2'b00, pd1});
        mon(2, {1'b0, pd2});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [8:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.perr = p;
        exq[i].push_back(e);
    endtask

    task automatic start(input int i, input logic with_bit);
        fs[i] = 1'b1;
        sv[i] = with_bit;
        sd[i] = 1'b1;
        tick();
        fs[i] = 1'b0;
        sv[i] = 1'b0;
    endtask

    task automatic send_bit(input int i, input logic b);
        sd[i] = b;
        sv[i] = 1'b1;
        tick();
        sv[i] = 1'b0;
        tick();
    endtask

    task automatic bits(input int i, input logic [8:0] tx, input int n);
        for (int k = 0; k < n; k++) send_bit(i, tx[k]);
    endtask

    task automatic frame(input int i, input logic [8:0] tx, input int n, input logic stop);
        start(i, 1'b0);
        bits(i, tx, n);
        send_bit(i, stop);
    endtask

    // Transmission order for the MSB-first 7-bit instance.
    function automatic logic [8:0] msb7(input logic [6:0] d);
        logic [8:0] tx;
        tx = 9'd0;
        for (int k = 0; k < 7; k++) tx[k] = d[6-k];
        return tx;
    endfunction

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fs[i] = 1'b0; sd[i] = 1'b0; sv[i] = 1'b0; rdy[i] = 1'b1;
            fe_cnt[i] = 0; ov_cnt[i] = 0; dvh_cnt[i] = 0;
        end
        tick();
        tick();
        chk("reset_pd", {24'd0, pd0}, 32'h0);
        chk("reset_dv", {31'd0, dv[0]}, 32'h0);
        chk("reset_perr", {31'd0, pe[0]}, 32'h0);
        chk("reset_ferr", {31'd0, fe[0]}, 32'h0);
        chk("reset_ovr", {31'd0, ov[0]}, 32'h0);
        chk("reset_busy", {31'd0, bz[0]}, 32'h0);
        rst = 1'b0;
        tick();

        push(0, 9'h0A5, 1'b0);
        frame(0, 9'h0A5, 8, 1'b1);
        tick();
        tick();
        chk("a5_valid_cycles", dvh_cnt[0], 32'd1);
        chk("idle_busy", {31'd0, bz[0]}, 32'h0);

        push(0, 9'h000, 1'b0);
        frame(0, 9'h000, 8, 1'b1);
        push(0, 9'h0FF, 1'b0);
        frame(0, 9'h0FF, 8, 1'b1);

        // Samples in IDLE must not start or affect anything.
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);

        frame(0, 9'h055, 8, 1'b0);
        tick();
        tick();
        chk("frame_err_pulse", fe_cnt[0], 32'd1);
        chk("frame_err_no_word", {31'd0, dv[0]}, 32'h0);

        start(0, 1'b0);
        bits(0, 9'h1FF, 4);
        chk("busy_in_frame", {31'd0, bz[0]}, 32'h1);
        push(0, 9'h03C, 1'b0);
        frame(0, 9'h03C, 8, 1'b1);
        tick();
        chk("abort_no_ferr", fe_cnt[0], 32'd1);

        push(0, 9'h096, 1'b0);
        start(0, 1'b1);
        bits(0, 9'h096, 8);
        send_bit(0, 1'b1);

        push(1, 9'h041, 1'b0);
        frame(1, msb7(7'h41), 7, 1'b1);

        rdy[1] = 1'b0;
        push(1, 9'h011, 1'b0);
        frame(1, msb7(7'h11), 7, 1'b1);
        frame(1, msb7(7'h22), 7, 1'b1);
        tick();
        tick();
        chk("overrun_pulse", ov_cnt[1], 32'd1);
        chk("held_valid", {31'd0, dv[1]}, 32'h1);
        rdy[1] = 1'b1;
        tick();
        tick();
        chk("drained_valid", {31'd0, dv[1]}, 32'h0);
        chk("drained_queue", exq[1].size(), 32'd0);

        push(2, 9'h003, 1'b1);
        frame(2, 9'h103, 9, 1'b1);
        push(2, 9'h003, 1'b0);
        frame(2, 9'h003, 9, 1'b1);
        push(2, 9'h007, 1'b0);
        frame(2, 9'h107, 9, 1'b1);
        push(2, 9'h007, 1'b1);
        frame(2, 9'h007, 9, 1'b1);

        // Reset with a held word on dut1 and a half-received frame on dut0.
        rdy[1] = 1'b0;
        push(1, 9'h015, 1'b0);
        frame(1, msb7(7'h15), 7, 1'b1);
        tick();
        start(0, 1'b0);
        bits(0, 9'h0FF, 4);
        rst = 1'b1;
        #1;
        exq[1].delete();
        chk("async_rst_pd", {24'd0, pd0}, 32'h0);
        chk("async_rst_busy", {31'd0, bz[0]}, 32'h0);
        chk("async_rst_held", {31'd0, dv[1]}, 32'h0);
        tick();
        rst = 1'b0;
        rdy[1] = 1'b1;
        tick();
        push(0, 9'h05A, 1'b0);
        frame(0, 9'h05A, 8, 1'b1);
        tick();
        tick();
        chk("post_rst_ferr", fe_cnt[0], 32'd1);
        chk("post_rst_ovr0", ov_cnt[0], 32'd0);
        chk("post_rst_ovr1", ov_cnt[1], 32'd1);
        chk("post_rst_dv1", {31'd0, dv[1]}, 32'h0);

        for (int t = 0; t < 20; t++) begin
            if (exq[0].size() == 0 && exq[1].size() == 0 && exq[2].size() == 0) break;
            tick();
        end
        chk("pending_dut0", exq[0].size(), 32'd0);
        chk("pending_dut1", exq[1].size(), 32'd0);
        chk("pending_dut2", exq[2].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
